// File: rtl/instr_mem_arbiter.sv
// Instruction memory port arbiter: shares one memory port between NUM_CORES
// fetch requesters (round-robin) and a program-load write path that always
// takes precedence. Reads are fully pipelined; each grant returns exactly one
// RData_Valid pulse one cycle after the read strobe.
module instr_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 14
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_CORES-1:0]    Req,
    input  logic [32*NUM_CORES-1:0] PC_in,
    input  logic                    Load_En,
    input  logic [ADDR_W-1:0]       Load_Addr,
    input  logic [31:0]             Load_Data,
    input  logic [31:0]             Mem_RData,
    output logic [NUM_CORES-1:0]    Grant,
    output logic [NUM_CORES-1:0]    RData_Valid,
    output logic [31:0]             RData,
    output logic [ADDR_W-1:0]       Mem_Addr,
    output logic                    Mem_RdEn,
    output logic                    Mem_WrEn,
    output logic [31:0]             Mem_WData,
    output logic                    Busy
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    // One-hot so the read and write strobes come straight off state flops.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_READ = 3'b010,
        ST_LOAD = 3'b100
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_CORES-1:0]   grant_q, grant_d;
    logic [NUM_CORES-1:0]   rvalid_q;
    logic [31:0]            rdata_q;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   busy_q, busy_d;
    logic [IDX_W-1:0]       last_q, last_d;

    logic [NUM_CORES-1:0]   eligible;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [ADDR_W-1:0]      pc_word [NUM_CORES];
    logic                   unused_pc_bits;

    // Byte-offset and high PC bits are don't-cares; fold them so every input bit has a reader.
    assign unused_pc_bits = ^PC_in;

    // Extract each core's word address from its byte PC (wraps modulo 2^ADDR_W words).
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            pc_word[i] = PC_in[32*i+2 +: ADDR_W];
        end
    end

    // Round-robin search starting just after the last winner; a core whose grant is
    // currently showing is excluded so one held request is never issued twice.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        eligible  = Req & ~grant_q;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            int c;
            c = (int'(last_q) + k) % NUM_CORES;
            if (!win_found && eligible[c]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(c);
            end
        end
    end

    // Next-state decision: loads pre-empt reads, otherwise read if anyone is eligible.
    always_comb begin
        if (Load_En) begin
            state_d = ST_LOAD;
        end else if (win_found) begin
            state_d = ST_READ;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Next values of the registered port outputs for the chosen state.
    always_comb begin
        grant_d = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        case (state_d)
            ST_LOAD: begin
                addr_d  = Load_Addr;
                wdata_d = Load_Data;
            end
            ST_READ: begin
                grant_d[win_idx] = 1'b1;
                addr_d           = pc_word[win_idx];
                last_d           = win_idx;
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, registered outputs and the one-cycle read-return pipeline.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (Reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            last_q   <= IDX_W'(NUM_CORES - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rvalid_q <= grant_q;
            rdata_q  <= (|rvalid_q) ? Mem_RData : rdata_q;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            last_q   <= last_d;
        end
    end

    assign Grant       = grant_q;
    assign RData_Valid = rvalid_q;
    assign RData       = (|rvalid_q) ? Mem_RData : rdata_q;
    assign Mem_Addr    = addr_q;
    assign Mem_RdEn    = state_q[1];
    assign Mem_WrEn    = state_q[2];
    assign Mem_WData   = wdata_q;
    assign Busy        = busy_q;

endmodule
